// File: rtl/hmc7044_spi_cfg.sv
// hmc7044_spi_cfg
// Walks a table of REG_NUM 24-bit write words and sends each one to the
// HMC7044 as a single SPI mode-0 write frame. SCLK is derived from clk with
// a half-period of DIV_HALF cycles. busy covers the whole pass, and done
// pulses once when the last frame's inter-frame gap has elapsed.
module hmc7044_spi_cfg #(
    parameter int DIV_HALF = 4,
    parameter int REG_NUM  = 8,
    parameter int IDX_W    = 8,
    parameter int CS_GAP   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IDX_W-1:0] cfg_idx,
    input  logic [23:0]      cfg_data,
    output logic             spi_csn,
    output logic             spi_sclk,
    output logic             spi_sdio,
    output logic             busy,
    output logic             done
);

    // One shared counter times CS setup, SCLK half-periods, CS hold and the gap,
    // so it must reach the larger of DIV_HALF-1 and CS_GAP-1.
    localparam int CNT_MAX = (DIV_HALF > CS_GAP) ? DIV_HALF : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_CS_SETUP = 3'd2;
    localparam logic [2:0] S_SHIFT    = 3'd3;
    localparam logic [2:0] S_CS_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;

    logic [2:0]       state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [4:0]       bit_cnt_reg, bit_cnt_next;
    // Bit 23 goes straight to spi_sdio in LOAD, so only the remaining 23 bits
    // need to be held for shifting.
    logic [22:0]      shreg_reg,   shreg_next;
    logic [IDX_W-1:0] idx_reg,     idx_next;
    logic             csn_reg,     csn_next;
    logic             sclk_reg,    sclk_next;
    logic             sdio_reg,    sdio_next;
    logic             busy_reg,    busy_next;
    logic             done_reg,    done_next;

    logic half_wrap;
    logic gap_wrap;
    logic last_idx;

    assign half_wrap = (cnt_reg == CNT_W'(DIV_HALF - 1));
    assign gap_wrap  = (cnt_reg == CNT_W'(CS_GAP - 1));
    assign last_idx  = (idx_reg == IDX_W'(REG_NUM - 1));

    // Next-state and next-output logic for the configuration sequencer.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shreg_next   = shreg_reg;
        idx_next     = idx_reg;
        csn_next     = csn_reg;
        sclk_next    = sclk_reg;
        sdio_next    = sdio_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    idx_next   = '0;
                    busy_next  = 1'b1;
                    state_next = S_LOAD;
                end
            end

            S_LOAD: begin
                shreg_next   = cfg_data[22:0];
                bit_cnt_next = 5'd24;
                sdio_next    = cfg_data[23];
                csn_next     = 1'b0;
                cnt_next     = '0;
                state_next   = S_CS_SETUP;
            end

            S_CS_SETUP: begin
                if (half_wrap) begin
                    cnt_next   = '0;
                    state_next = S_SHIFT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            S_SHIFT: begin
                if (half_wrap) begin
                    cnt_next  = '0;
                    sclk_next = ~sclk_reg;
                    if (!sclk_reg) begin
                        // Rising edge: the slave samples the bit now on sdio.
                        bit_cnt_next = bit_cnt_reg - 5'd1;
                    end else if (bit_cnt_reg != 5'd0) begin
                        // Falling edge: present the next bit.
                        sdio_next  = shreg_reg[22];
                        shreg_next = {shreg_reg[21:0], 1'b0};
                    end else begin
                        // 24th falling edge: frame payload complete.
                        state_next = S_CS_HOLD;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            S_CS_HOLD: begin
                if (half_wrap) begin
                    cnt_next   = '0;
                    csn_next   = 1'b1;
                    sdio_next  = 1'b0;
                    state_next = S_GAP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            S_GAP: begin
                if (gap_wrap) begin
                    cnt_next = '0;
                    if (last_idx) begin
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = S_LOAD;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= 5'd0;
            shreg_reg   <= '0;
            idx_reg     <= '0;
            csn_reg     <= 1'b1;
            sclk_reg    <= 1'b0;
            sdio_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shreg_reg   <= shreg_next;
            idx_reg     <= idx_next;
            csn_reg     <= csn_next;
            sclk_reg    <= sclk_next;
            sdio_reg    <= sdio_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign cfg_idx  = idx_reg;
    assign spi_csn  = csn_reg;
    assign spi_sclk = sclk_reg;
    assign spi_sdio = sdio_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_hmc7044_spi_cfg.sv
// Testbench for hmc7044_spi_cfg. Two instances: the default configuration
// with a two-entry table, and a fast one (DIV_HALF=2, CS_GAP=1, REG_NUM=1).
// Stimulus pushes the expected frame words and done cycle into queues; a
// negedge monitor acting as an SPI slave pops and compares them.
`timescale 1ns/1ps
module tb_hmc7044_spi_cfg;

    localparam int IDX_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic [IDX_W-1:0] idx0, idx1;
    logic [23:0]      data0, data1;
    logic csn0, sclk0, sdio0, busy0, done0;
    logic csn1, sclk1, sdio1, busy1, done1;

    logic [23:0] tbl0 [256];
    logic [23:0] tbl1 [256];

    assign data0 = tbl0[idx0];
    assign data1 = tbl1[idx1];

    hmc7044_spi_cfg #(.DIV_HALF(4), .REG_NUM(2), .IDX_W(IDX_W), .CS_GAP(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cfg_idx(idx0), .cfg_data(data0),
        .spi_csn(csn0), .spi_sclk(sclk0), .spi_sdio(sdio0), .busy(busy0), .done(done0)
    );

    hmc7044_spi_cfg #(.DIV_HALF(2), .REG_NUM(1), .IDX_W(IDX_W), .CS_GAP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cfg_idx(idx1), .cfg_data(data1),
        .spi_csn(csn1), .spi_sclk(sclk1), .spi_sdio(sdio1), .busy(busy1), .done(done1)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Active instance and its configuration as seen by the reference model.
    int act = 0;
    int cur_dh = 4;
    int cur_gap = 8;
    int cur_rn = 2;

    logic m_csn, m_sclk, m_sdio, m_busy, m_done;
    logic [IDX_W-1:0] m_idx;

    always_comb begin
        m_csn = csn0; m_sclk = sclk0; m_sdio = sdio0; m_busy = busy0; m_done = done0; m_idx = idx0;
        if (act != 0) begin
            m_csn = csn1; m_sclk = sclk1; m_sdio = sdio1; m_busy = busy1; m_done = done1; m_idx = idx1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Scoreboard queues.
    logic [23:0] exp_word_q[$];
    int          exp_done_q[$];

    // SPI slave / protocol monitor.
    logic p_csn = 1'b1, p_sclk = 1'b0, p_sdio = 1'b0, p_done = 1'b0;
    logic [23:0] cap = '0;
    int rises = 0, falls = 0, low_len = 0, high_len = 0, frame_no = 0;
    int last_rise = 0, last_chg = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_csn = 1'b1; p_sclk = 1'b0; p_sdio = 1'b0; p_done = 1'b0;
            rises = 0; falls = 0; low_len = 0; high_len = 0; frame_no = 0; cap = '0;
        end else begin
            if (p_csn && !m_csn) begin
                if (frame_no > 0) check("cs_high_between_frames", high_len, cur_gap + 1);
                check("cfg_idx_at_frame", m_idx, frame_no);
                rises = 0; falls = 0; cap = '0; low_len = 0;
                last_chg = cyc;
            end
            if (m_csn) check("sclk_idle_low", m_sclk, 1'b0);
            if ((m_sdio !== p_sdio) && !m_csn && !p_csn) begin
                if (rises > 0) check("sdio_hold_after_rise", (cyc - last_rise) >= cur_dh, 1'b1);
                last_chg = cyc;
            end
            if (!p_sclk && m_sclk && !m_csn) begin
                check("sdio_setup_before_rise", (cyc - last_chg) >= cur_dh, 1'b1);
                if (rises > 0) check("sclk_period", cyc - last_rise, 2 * cur_dh);
                cap = {cap[22:0], m_sdio};
                rises++;
                last_rise = cyc;
            end
            if (p_sclk && !m_sclk) falls++;
            if (!p_csn && m_csn) begin
                check("csn_low_cycles", low_len, 50 * cur_dh);
                check("rising_edges", rises, 24);
                check("falling_edges", falls, 24);
                if (exp_word_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_frame: got 0x%06h, required no frame", cap);
                end else begin
                    check("frame_word", cap, exp_word_q.pop_front());
                end
                $display("[TB] inst %0d frame %0d captured 0x%06h at cycle %0d", act, frame_no, cap, cyc);
                frame_no++;
                high_len = 0;
            end
            if (!m_csn) low_len++; else high_len++;
            if (m_done) begin
                done_cnt++;
                check("done_single_pulse", p_done, 1'b0);
                if (exp_done_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
                end else begin
                    check("done_cycle", cyc, exp_done_q.pop_front());
                end
                check("busy_low_at_done", m_busy, 1'b0);
                check("idx_at_done", m_idx, cur_rn - 1);
                check("frames_per_pass", frame_no, cur_rn);
                $display("[TB] inst %0d done at cycle %0d", act, cyc);
                frame_no = 0;
            end
            p_csn = m_csn; p_sclk = m_sclk; p_sdio = m_sdio; p_done = m_done;
        end
    end

    function automatic int pitch();
        return 1 + 50 * cur_dh + cur_gap;
    endfunction

    task automatic set_start(input logic v);
        if (act == 0) start0 = v; else start1 = v;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Issue an accepted start (called at a negedge) and post its expectations.
    task automatic begin_pass(output int se);
        for (int k = 0; k < cur_rn; k++) exp_word_q.push_back(act == 0 ? tbl0[k] : tbl1[k]);
        se = cyc + 1;
        exp_done_q.push_back(se + cur_rn * pitch());
        $display("[TB] inst %0d start sampled at cycle %0d", act, se);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check("busy_after_start", m_busy, 1'b1);
        check("idx_after_start", m_idx, 0);
    endtask

    // A start pulse the DUT must ignore (no expectations posted).
    task automatic stray_start();
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
    endtask

    int se, se2, e, exp_done_total;

    initial begin
        exp_done_total = 0;
        for (int k = 0; k < 256; k++) begin
            tbl0[k] = '0;
            tbl1[k] = '0;
        end

        // Reset values of both instances.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_csn0", csn0, 1'b1);  check("rst_sclk0", sclk0, 1'b0);
        check("rst_sdio0", sdio0, 1'b0); check("rst_idx0", idx0, 0);
        check("rst_busy0", busy0, 1'b0); check("rst_done0", done0, 1'b0);
        check("rst_csn1", csn1, 1'b1);  check("rst_busy1", busy1, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table with stray starts mid-pass and on the done cycle,
        // then a start one cycle after done.
        tbl0[0] = 24'h000001;
        tbl0[1] = 24'h00A5C3;
        begin_pass(se);
        exp_done_total++;
        wait_until(se + 49);  stray_start();
        wait_until(se + 299); stray_start();
        e = se + 2 * pitch();
        wait_until(e - 1);    stray_start();
        begin_pass(se2);
        exp_done_total++;
        check("restart_after_done", se2, e + 1);
        wait_until(se2 + 2 * pitch() + 4);
        check("done_count_directed", done_cnt, exp_done_total);

        // Randomized tables.
        repeat (3) begin
            tbl0[0] = 24'($urandom);
            tbl0[1] = 24'($urandom);
            begin_pass(se);
            exp_done_total++;
            wait_until(se + 2 * pitch() + 4);
            check("done_count_random", done_cnt, exp_done_total);
        end

        // Reset around bit 10 of the second frame.
        tbl0[0] = 24'($urandom);
        tbl0[1] = 24'($urandom);
        begin_pass(se);
        wait_until(se + 1 + pitch() + cur_dh + 2 * cur_dh * 10);
        check("csn_low_before_reset", m_csn, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_csn", m_csn, 1'b1);
        check("async_rst_sclk", m_sclk, 1'b0);
        check("async_rst_busy", m_busy, 1'b0);
        check("async_rst_sdio", m_sdio, 1'b0);
        exp_word_q.delete();
        exp_done_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_until(cyc + 600);
        check("no_done_after_abort", done_cnt, exp_done_total);
        begin_pass(se);
        exp_done_total++;
        wait_until(se + 2 * pitch() + 4);
        check("done_count_after_reset", done_cnt, exp_done_total);

        // Fast instance: all-ones word, then a start one cycle after done.
        act = 1; cur_dh = 2; cur_gap = 1; cur_rn = 1;
        tbl1[0] = 24'hFFFFFF;
        @(negedge clk);
        begin_pass(se);
        exp_done_total++;
        check("fast_done_offset", se + pitch(), se + 102);
        e = se + pitch();
        wait_until(e);
        begin_pass(se2);
        exp_done_total++;
        wait_until(se2 + pitch() + 4);
        check("done_count_fast", done_cnt, exp_done_total);
        repeat (3) begin
            tbl1[0] = 24'($urandom);
            begin_pass(se);
            exp_done_total++;
            wait_until(se + pitch() + 4);
            check("done_count_fast_random", done_cnt, exp_done_total);
        end

        repeat (5) @(negedge clk);
        check("word_queue_empty", exp_word_q.size(), 0);
        check("done_queue_empty", exp_done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
